// File: rtl/quick_attack_sequencer.sv
// quick_attack_sequencer: erase/move/redraw/wait-frame controller for the Pikachu quick-attack block.
// Ports: clock, reset_all (async, active-high); start/busy/attack_done to the battle FSM;
// done_animate/done_pikachu/done_quick_attack/p_qa_colour from the quick-attack block;
// qa_reset_n/enable_animate/enable_p_qa/enable_draw_pika to it; vga_colour/vga_plot to the VGA adapter;
// step_count = move steps in this attack (saturating); wd_error = sticky watchdog flag.
// Optional: define QA_WATCHDOG_EN to bound each erase/draw phase to WD_CYCLES clocks.
module quick_attack_sequencer #(
  parameter logic [2:0]  ERASE_COLOUR = 3'b000,
  parameter logic [15:0] WD_CYCLES    = 16'd20000
) (
  input  logic       clock,
  input  logic       reset_all,
  input  logic       start,
  input  logic       done_animate,
  input  logic       done_pikachu,
  input  logic       done_quick_attack,
  input  logic [2:0] p_qa_colour,
  output logic       qa_reset_n,
  output logic       enable_animate,
  output logic       enable_p_qa,
  output logic       enable_draw_pika,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       busy,
  output logic       attack_done,
  output logic [7:0] step_count,
  output logic       wd_error
);
  typedef enum logic [2:0] {IDLE, ERASE, GAP1, MOVE, DRAW, GAP2, WAIT_FRAME, FINISH} state_t;
  state_t state, nxt;
  logic first, frame_pending, quit, erasing, drawing, wd;
  // The attack-complete check happens on the first ERASE cycle, so that cycle must not plot.
  assign quit = state == ERASE && first && done_quick_attack;
  assign erasing = state == ERASE && !quit;
  assign drawing = state == DRAW;
  assign enable_draw_pika = erasing | drawing;
  assign vga_plot = erasing | drawing;
  assign vga_colour = drawing ? p_qa_colour : erasing ? ERASE_COLOUR : 3'b000;
`ifdef QA_WATCHDOG_EN
  logic [15:0] wd_cnt;
  assign wd = (erasing | drawing) && wd_cnt == WD_CYCLES - 16'd1;
  always_ff @(posedge clock or posedge reset_all) begin
    if (reset_all) begin
      wd_cnt <= 16'd0;
      wd_error <= 1'b0;
    end else begin
      wd_cnt <= nxt != state ? 16'd0 : wd_cnt + 16'd1;
      wd_error <= wd_error | wd;
    end
  end
`else
  logic unused_wd;
  assign unused_wd = ^WD_CYCLES;
  assign wd = 1'b0;
  assign wd_error = 1'b0;
`endif
  always_comb begin
    nxt = state;
    case (state)
      IDLE:       nxt = start ? ERASE : IDLE;
      ERASE:      nxt = quit ? FINISH : done_pikachu ? GAP1 : wd ? FINISH : ERASE;
      GAP1:       nxt = MOVE;
      MOVE:       nxt = DRAW;
      DRAW:       nxt = done_pikachu ? GAP2 : wd ? FINISH : DRAW;
      GAP2:       nxt = WAIT_FRAME;
      WAIT_FRAME: nxt = (frame_pending | done_animate) ? ERASE : WAIT_FRAME;
      default:    nxt = IDLE;
    endcase
  end
  // Control outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clock or posedge reset_all) begin
    if (reset_all) begin
      state <= IDLE;
      first <= 1'b0;
      frame_pending <= 1'b0;
      step_count <= 8'd0;
      busy <= 1'b0;
      qa_reset_n <= 1'b0;
      enable_animate <= 1'b0;
      enable_p_qa <= 1'b0;
      attack_done <= 1'b0;
    end else begin
      state <= nxt;
      first <= nxt != state;
      step_count <= (state == IDLE && start) ? 8'd0 :
                    (state == MOVE && step_count != 8'hFF) ? step_count + 8'd1 : step_count;
      frame_pending <= (state == IDLE || (state == WAIT_FRAME && nxt == ERASE)) ? 1'b0 :
                       (done_animate && state inside {ERASE, GAP1, MOVE, DRAW, GAP2}) ? 1'b1 : frame_pending;
      busy <= nxt != IDLE;
      qa_reset_n <= !(nxt inside {IDLE, FINISH});
      enable_animate <= nxt inside {ERASE, GAP1, MOVE, DRAW, GAP2, WAIT_FRAME};
      enable_p_qa <= nxt == MOVE;
      attack_done <= nxt == FINISH;
    end
  end
endmodule

// File: tb/tb_quick_attack_sequencer.sv
// tb_quick_attack_sequencer: directed self-checking bench for quick_attack_sequencer.
module tb_quick_attack_sequencer;
  logic clock = 1'b0, reset_all = 1'b1, start = 1'b0, auto = 1'b0;
  logic dp_man = 1'b0, da_man = 1'b0, dqa_man = 1'b0;
  logic [2:0] p_qa_colour = 3'b110;
  logic done_animate, done_pikachu, done_quick_attack;
  logic qa_reset_n, enable_animate, enable_p_qa, enable_draw_pika, vga_plot, busy, attack_done, wd_error;
  logic [2:0] vga_colour;
  logic [7:0] step_count;
  int checks = 0, errors = 0, pk_cnt = 0, an_cnt = 0, frames = 0, n_pqa = 0, n_done = 0;
  int n, base_pqa, base_done;
`ifdef QA_WATCHDOG_EN
  localparam logic [15:0] WD = 16'd100;
`else
  localparam logic [15:0] WD = 16'd20000;
`endif
  always #5 clock = ~clock;
  always @(posedge clock) begin
    pk_cnt <= enable_draw_pika ? pk_cnt + 1 : 0;
    an_cnt <= enable_animate ? (an_cnt == 49 ? 0 : an_cnt + 1) : 0;
    frames <= !qa_reset_n ? 0 : frames + (done_animate ? 1 : 0);
  end
  always @(negedge clock) begin
    if (enable_p_qa) n_pqa++;
    if (attack_done) n_done++;
  end
  assign done_pikachu = auto ? pk_cnt >= 10 : dp_man;
  assign done_animate = auto ? (enable_animate && an_cnt == 49) : da_man;
  assign done_quick_attack = auto ? frames >= 3 : dqa_man;
  quick_attack_sequencer #(.WD_CYCLES(WD)) dut (
    .clock(clock), .reset_all(reset_all), .start(start), .done_animate(done_animate),
    .done_pikachu(done_pikachu), .done_quick_attack(done_quick_attack), .p_qa_colour(p_qa_colour),
    .qa_reset_n(qa_reset_n), .enable_animate(enable_animate), .enable_p_qa(enable_p_qa),
    .enable_draw_pika(enable_draw_pika), .vga_colour(vga_colour), .vga_plot(vga_plot),
    .busy(busy), .attack_done(attack_done), .step_count(step_count), .wd_error(wd_error)
  );
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, got, exp);
    end
  endtask
  initial begin
    repeat (2) tick;
    check("rst_ctl", 16'({busy, qa_reset_n, enable_animate, enable_p_qa, enable_draw_pika, vga_plot, attack_done, wd_error}), 16'd0);
    check("rst_col", 16'(vga_colour), 16'd0);
    check("rst_step", 16'(step_count), 16'd0);
    reset_all = 1'b0;
    tick;
    start = 1'b1; tick; start = 1'b0;
    check("erase_ctl", 16'({busy, qa_reset_n, enable_animate, enable_draw_pika, vga_plot, enable_p_qa}), 16'b111110);
    check("erase_col", 16'(vga_colour), 16'd0);
    da_man = 1'b1; tick; da_man = 1'b0;
    check("erase_hold", 16'(vga_plot), 16'd1);
    dp_man = 1'b1; tick; dp_man = 1'b0;
    check("gap1", 16'({enable_draw_pika, vga_plot, vga_colour, enable_animate}), 16'b000001);
    tick;
    check("move", 16'({enable_p_qa, step_count}), 16'h100);
    tick;
    check("draw", 16'({enable_p_qa, vga_plot, enable_draw_pika, vga_colour}), 16'b011110);
    check("step1", 16'(step_count), 16'd1);
    da_man = 1'b1; start = 1'b1; tick; da_man = 1'b0; start = 1'b0;
    check("draw_busy", 16'({busy, vga_plot}), 16'b11);
    check("start_ignored", 16'(step_count), 16'd1);
    dp_man = 1'b1; tick; dp_man = 1'b0;
    check("gap2", 16'({vga_plot, enable_draw_pika, enable_p_qa, enable_animate}), 16'b0001);
    tick;
    check("wait", 16'({vga_plot, enable_animate, busy}), 16'b011);
    tick;
    check("early_frame", 16'({vga_plot, enable_draw_pika, vga_colour}), 16'b11000);
    dp_man = 1'b1; tick;
    check("gap1_b", 16'(vga_plot), 16'd0);
    tick; tick;
    check("draw_b", 16'({vga_plot, vga_colour}), 16'b1110);
    tick; dp_man = 1'b0;
    check("draw_one_cycle", 16'(vga_plot), 16'd0);
    check("step2", 16'(step_count), 16'd2);
    tick; tick;
    check("pending_cleared", 16'({busy, enable_animate, vga_plot}), 16'b110);
    dqa_man = 1'b1; da_man = 1'b1; tick; da_man = 1'b0;
    check("qa_skip", 16'({vga_plot, enable_draw_pika, busy}), 16'b001);
    tick;
    check("finish", 16'({attack_done, qa_reset_n, busy}), 16'b101);
    check("step_hold", 16'(step_count), 16'd2);
    tick; dqa_man = 1'b0;
    check("idle", 16'({attack_done, busy, qa_reset_n}), 16'd0);
    check("idle_step", 16'(step_count), 16'd2);
    check("done_pulses", 16'(n_done), 16'd1);
    start = 1'b1; tick; start = 1'b0;
    dp_man = 1'b1; tick; dp_man = 1'b0;
    tick; tick;
    check("draw_c", 16'(vga_plot), 16'd1);
    reset_all = 1'b1; #2;
    check("async_rst", 16'({busy, qa_reset_n, enable_animate, enable_p_qa, enable_draw_pika, vga_plot, attack_done, vga_colour, step_count}), 16'd0);
    tick;
    check("rst_edge", 16'({busy, qa_reset_n, enable_animate, vga_plot, vga_colour}), 16'd0);
    reset_all = 1'b0; tick;
    base_pqa = n_pqa; base_done = n_done; auto = 1'b1;
    start = 1'b1; tick; start = 1'b0;
    n = 0;
    while (busy && n < 2000) begin tick; n++; end
    check("nominal_end", 16'(busy), 16'd0);
    check("nominal_pqa", 16'(n_pqa - base_pqa), 16'd3);
    check("nominal_step", 16'(step_count), 16'd3);
    check("nominal_done", 16'(n_done - base_done), 16'd1);
    auto = 1'b0;
`ifdef QA_WATCHDOG_EN
    start = 1'b1; tick; start = 1'b0;
    n = 0;
    while (!attack_done && n < 300) begin tick; n++; end
    check("wd_cycles", 16'(n), 16'd100);
    check("wd_flag", 16'(wd_error), 16'd1);
    tick;
    check("wd_idle", 16'({busy, wd_error}), 16'b01);
`else
    check("wd_off", 16'(wd_error), 16'd0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/quick_attack_sequencer.md
Name: quick_attack_sequencer

Overview:
- Master-side controller for the Pikachu quick-attack animation block.
- Generates that block's enables (enable_animate, enable_p_qa, enable_draw_pika) and its active-low sub-reset.
- Consumes its done_animate, done_pikachu and done_quick_attack indications.
- Sequences erase -> move -> redraw -> wait-frame per animation step; muxes sprite colour vs erase colour into the VGA plot stream. Sits between the battle FSM (start/busy/done) and the quick-attack block plus the VGA adapter.

Parameters:
- ERASE_COLOUR, 3'b000, colour written over the old sprite during erase.
- WD_CYCLES, 16'd20000, watchdog limit in clocks per draw/erase phase (used only with QA_WATCHDOG_EN).

Ports:
- clock  in  1  system clock, all state on posedge.
- reset_all  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request from battle FSM; accepted only in IDLE.
- done_animate  in  1  one-cycle frame pulse from the quick-attack block.
- done_pikachu  in  1  level, high when the sprite draw pass is complete.
- done_quick_attack  in  1  level, high when the attack frame count is reached.
- p_qa_colour  in  3  sprite pixel colour from the quick-attack block.
- qa_reset_n  out  1  active-low reset driven to the quick-attack block.
- enable_animate  out  1  frame counter enable.
- enable_p_qa  out  1  one-cycle position step enable.
- enable_draw_pika  out  1  draw pass enable.
- vga_colour  out  3  colour to the VGA adapter.
- vga_plot  out  1  VGA write enable.
- busy  out  1  high in any state other than IDLE.
- attack_done  out  1  one-cycle completion pulse.
- step_count  out  8  number of move steps in the current attack, saturating.
- wd_error  out  1  sticky watchdog flag (0 when the feature is compiled out).

Behaviour:
- Reset (async, reset_all=1):
  - State IDLE; all outputs 0, including qa_reset_n=0.
  - step_count=0, frame_pending=0.
- States: IDLE, ERASE, GAP1, MOVE, DRAW, GAP2, WAIT_FRAME, FINISH.
- IDLE:
  - qa_reset_n=0, holding the sub-block cleared; busy=0.
  - start=1 -> ERASE, step_count<=0, frame_pending<=0.
- qa_reset_n=1 in every state except IDLE and FINISH.
- enable_animate=1 in ERASE through WAIT_FRAME.
- ERASE:
  - If done_quick_attack=1 on the entry cycle -> FINISH; no erase is performed.
  - Otherwise enable_draw_pika=1, vga_colour=ERASE_COLOUR, vga_plot=1.
  - Stays until done_pikachu=1, then -> GAP1.
- GAP1:
  - enable_draw_pika=0 for exactly one cycle so the draw pass counter rearms. -> MOVE.
- MOVE:
  - enable_p_qa=1 for exactly one cycle.
  - step_count<=step_count+1, saturating at 8'hFF. -> DRAW.
- DRAW:
  - enable_draw_pika=1, vga_colour=p_qa_colour, vga_plot=1.
  - done_pikachu=1 -> GAP2.
- GAP2: one cycle with enables low. -> WAIT_FRAME.
- WAIT_FRAME:
  - Exits to ERASE when frame_pending=1 or done_animate=1 this cycle.
  - frame_pending is cleared on exit.
- frame_pending:
  - Set by any done_animate pulse seen in ERASE..GAP2, so no frame pulse is lost.
  - Multiple pulses in one step collapse to one.
- FINISH:
  - attack_done=1 for one cycle; qa_reset_n=0. -> IDLE.
  - step_count holds its value until the next accepted start.
- vga_plot=0 and vga_colour=0 in all states except ERASE and DRAW.
- start while busy: ignored, no queueing.
- done_pikachu already high on entry to ERASE or DRAW: the phase lasts exactly one cycle.
- Reset asserted mid-attack: immediate return to IDLE values; the sub-block is cleared via qa_reset_n=0.

Optional Feature:
- Macro: QA_WATCHDOG_EN.
- Defined:
  - A 16-bit counter clears on entry to ERASE or DRAW and increments each cycle in those states.
  - On reaching WD_CYCLES: wd_error<=1 (sticky until reset_all), then -> FINISH with attack_done pulsed.
- Undefined: no counter; wd_error tied 0; ERASE and DRAW wait indefinitely.

Test Plan:
1. Reset: reset_all=1 mid-DRAW -> next edge all outputs 0, qa_reset_n=0, busy=0.
2. Nominal run:
   - Stimulus: start pulse; done_pikachu high 10 cycles after each enable; done_animate every 50 cycles; done_quick_attack high after 3 frames.
   - Required: exactly 3 enable_p_qa pulses, step_count=3, one attack_done pulse, then busy=0.
3. Early frame: done_animate pulses during DRAW -> WAIT_FRAME lasts 1 cycle, then ERASE; no frame lost.
4. Colour mux:
   - p_qa_colour=3'b110 in DRAW -> vga_colour=110, vga_plot=1.
   - In ERASE -> vga_colour=000.
   - In GAP1 -> vga_plot=0.
5. start while busy -> ignored; step_count is not cleared; only one attack_done pulse.
6. QA_WATCHDOG_EN defined, WD_CYCLES=100, done_pikachu held 0 -> after 100 cycles in ERASE: wd_error=1, attack_done pulse, IDLE.
